// File: rtl/pc_cfr_pkg.sv
// Shared types and helpers for the peak-cancellation CFR blocks.
//   pc_cfr_peak_t   : one detected peak (excess magnitude, CORDIC angle, polyphase index)
//   onehot_rr_pick  : first set request at or above a start index, wrapping over n entries
package pc_cfr_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ITERATIONS = 7;
  localparam int MAX_CPG    = 16;
  localparam int CPG_IDX_W  = 4;

  typedef struct packed {
    logic [DATA_WIDTH:0] r;
    logic [ITERATIONS:0] theta;
    logic                phase;
  } pc_cfr_peak_t;

  // Scans n entries starting at ptr; only the first hit is marked, so the
  // result is one-hot or zero. Entries at index >= n are never examined.
  function automatic logic [MAX_CPG-1:0] onehot_rr_pick(
    input logic [MAX_CPG-1:0]   req,
    input logic [CPG_IDX_W-1:0] ptr,
    input int                   n
  );
    logic [MAX_CPG-1:0]   pick;
    logic [CPG_IDX_W-1:0] idx;
    pick = '0;
    for (int k = 0; k < MAX_CPG; k++) begin
      idx = CPG_IDX_W'((int'(ptr) + k) % n);
      if ((k < n) && (pick == '0) && req[idx]) pick[idx] = 1'b1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/pc_cfr_cpg_alloc_if.sv
// Peak-in / CPG-out bundle of the CPG allocator.
//   peak_*  : peak from the detector (peak_valid may be high every cycle)
//   cpg_*   : one-hot start strobe, shared payload bus and per-CPG occupancy
// master = peak detector / CPG array side, slave = allocator.
interface pc_cfr_cpg_alloc_if #(
  parameter int ITERATIONS = 7,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CPG    = 4
);
  logic [DATA_WIDTH:0] peak_r;
  logic [ITERATIONS:0] peak_theta;
  logic                peak_phase;
  logic                peak_valid;
  logic [NUM_CPG-1:0]  cpg_start;
  logic [DATA_WIDTH:0] cpg_r;
  logic [ITERATIONS:0] cpg_theta;
  logic                cpg_phase;
  logic [NUM_CPG-1:0]  cpg_busy;

  modport master (
    output peak_r, peak_theta, peak_phase, peak_valid,
    input  cpg_start, cpg_r, cpg_theta, cpg_phase, cpg_busy
  );

  modport slave (
    input  peak_r, peak_theta, peak_phase, peak_valid,
    output cpg_start, cpg_r, cpg_theta, cpg_phase, cpg_busy
  );
endinterface

// File: rtl/pc_cfr_rr_arb.sv
// Combinational masked round-robin arbiter.
//   req       : eligible requesters (already masked by the caller)
//   ptr       : highest-priority index this cycle
//   grant     : one-hot winner, zero when req is zero
//   grant_idx : binary index of the winner (0 when no grant)
module pc_cfr_rr_arb #(
  parameter  int NUM_CPG = 4,
  localparam int IDX_W   = $clog2(NUM_CPG)
) (
  input  logic [NUM_CPG-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_CPG-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);
  import pc_cfr_pkg::*;

  logic [MAX_CPG-1:0] pick;

  always_comb begin
    pick      = onehot_rr_pick(MAX_CPG'(req), CPG_IDX_W'(ptr), NUM_CPG);
    grant     = NUM_CPG'(pick);
    grant_idx = '0;
    for (int i = 0; i < NUM_CPG; i++) begin
      if (grant[i]) grant_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/pc_cfr_cpg_alloc.sv
// Allocates detected peaks to a pool of cancellation pulse generators.
//   clk, rst_n      : clock, asynchronous active-low reset
//   alloc_if        : peak input, one-hot start + payload + busy output
//   ctrl_enable     : allocation enable (pulses in flight always finish)
//   ctrl_cpg_mask   : 1 = CPG may receive new grants
//   stat_clear      : synchronous clear of both statistics counters
//   stat_alloc_cnt  : saturating count of granted peaks
//   stat_drop_cnt   : saturating count of peaks dropped for lack of a free CPG
// A grant at cycle t starts the CPG at t+1; it then reads busy for PULSE_LEN
// cycles and becomes eligible again the cycle after busy falls.
module pc_cfr_cpg_alloc #(
  parameter int ITERATIONS = 7,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CPG    = 4,
  parameter int PULSE_LEN  = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pc_cfr_cpg_alloc_if.slave    alloc_if,
  input  logic                 ctrl_enable,
  input  logic [NUM_CPG-1:0]   ctrl_cpg_mask,
  input  logic                 stat_clear,
  output logic [CNT_WIDTH-1:0] stat_alloc_cnt,
  output logic [CNT_WIDTH-1:0] stat_drop_cnt
);
  import pc_cfr_pkg::*;

  localparam int IDX_W = $clog2(NUM_CPG);
  localparam int BW    = $clog2(PULSE_LEN + 1);

  logic [BW-1:0]        busy_cnt [NUM_CPG];
  logic [NUM_CPG-1:0]   busy, elig, grant, start_q;
  logic [IDX_W-1:0]     ptr_q, grant_idx, ptr_next;
  pc_cfr_peak_t         peak_in, payload_q;
  logic [CNT_WIDTH-1:0] alloc_cnt_q, drop_cnt_q;
  logic                 peak_act, grant_ok, drop;

  assign peak_in = '{r: alloc_if.peak_r, theta: alloc_if.peak_theta, phase: alloc_if.peak_phase};

  // Occupancy comes straight from the counters, so a CPG released at the end
  // of cycle t is only seen as free at t+1.
  always_comb begin
    for (int i = 0; i < NUM_CPG; i++) busy[i] = (busy_cnt[i] != '0);
  end

  assign elig     = ~busy & ctrl_cpg_mask;
  assign peak_act = alloc_if.peak_valid & ctrl_enable;
  assign grant_ok = peak_act & (|elig);
  assign drop     = peak_act & ~(|elig);
  assign ptr_next = (grant_idx == IDX_W'(NUM_CPG - 1)) ? '0 : grant_idx + IDX_W'(1);

  pc_cfr_rr_arb #(.NUM_CPG(NUM_CPG)) u_arb (
    .req       (elig),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CPG; i++) busy_cnt[i] <= '0;
      start_q   <= '0;
      payload_q <= '0;
      ptr_q     <= '0;
    end else begin
      for (int i = 0; i < NUM_CPG; i++) begin
        if (grant_ok && grant[i])   busy_cnt[i] <= BW'(PULSE_LEN);
        else if (busy_cnt[i] != '0) busy_cnt[i] <= busy_cnt[i] - BW'(1);
      end
      start_q   <= grant_ok ? grant : '0;
      payload_q <= grant_ok ? peak_in : '0;
      if (grant_ok) ptr_q <= ptr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else if (stat_clear) begin
      alloc_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (grant_ok && (alloc_cnt_q != '1)) alloc_cnt_q <= alloc_cnt_q + CNT_WIDTH'(1);
      if (drop && (drop_cnt_q != '1))      drop_cnt_q  <= drop_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign alloc_if.cpg_start = start_q;
  assign alloc_if.cpg_r     = payload_q.r;
  assign alloc_if.cpg_theta = payload_q.theta;
  assign alloc_if.cpg_phase = payload_q.phase;
  assign alloc_if.cpg_busy  = busy;
  assign stat_alloc_cnt     = alloc_cnt_q;
  assign stat_drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_pc_cfr_cpg_alloc.sv
// Directed bench for pc_cfr_cpg_alloc with NUM_CPG=4, PULSE_LEN=8.
// Cycle t0 is the cycle in which a peak is driven; tick() advances to the
// next cycle and samples 1 time unit after the rising edge.
module tb_pc_cfr_cpg_alloc;
  logic        clk;
  logic        rst_n;
  logic        ctrl_enable;
  logic [3:0]  ctrl_cpg_mask;
  logic        stat_clear;
  logic [15:0] stat_alloc_cnt;
  logic [15:0] stat_drop_cnt;
  int          n_cmp = 0;
  int          n_err = 0;

  pc_cfr_cpg_alloc_if #(.ITERATIONS(7), .DATA_WIDTH(16), .NUM_CPG(4)) bus ();

  pc_cfr_cpg_alloc #(
    .ITERATIONS(7), .DATA_WIDTH(16), .NUM_CPG(4), .PULSE_LEN(8), .CNT_WIDTH(16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alloc_if       (bus),
    .ctrl_enable    (ctrl_enable),
    .ctrl_cpg_mask  (ctrl_cpg_mask),
    .stat_clear     (stat_clear),
    .stat_alloc_cnt (stat_alloc_cnt),
    .stat_drop_cnt  (stat_drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_peak(input logic v, input logic [16:0] r, input logic [7:0] th, input logic ph);
    bus.peak_valid = v;
    bus.peak_r     = r;
    bus.peak_theta = th;
    bus.peak_phase = ph;
  endtask

  task automatic apply_reset();
    rst_n         = 1'b0;
    set_peak(1'b0, 17'd0, 8'd0, 1'b0);
    ctrl_enable   = 1'b1;
    ctrl_cpg_mask = 4'hF;
    stat_clear    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (bus.cpg_start !== 4'b0000) begin n_err++; $display("FAIL reset_start: got %b exp 0000", bus.cpg_start); end
    n_cmp++; if (bus.cpg_busy !== 4'b0000) begin n_err++; $display("FAIL reset_busy: got %b exp 0000", bus.cpg_busy); end
    n_cmp++; if (bus.cpg_r !== 17'd0 || bus.cpg_theta !== 8'd0 || bus.cpg_phase !== 1'b0) begin
      n_err++; $display("FAIL reset_payload: got r=%0d th=%0d ph=%b exp 0/0/0", bus.cpg_r, bus.cpg_theta, bus.cpg_phase);
    end
    n_cmp++; if (stat_alloc_cnt !== 16'd0 || stat_drop_cnt !== 16'd0) begin
      n_err++; $display("FAIL reset_stats: got alloc=%0d drop=%0d exp 0/0", stat_alloc_cnt, stat_drop_cnt);
    end
  endtask

  task automatic test_single();
    apply_reset();
    set_peak(1'b1, 17'd100, 8'd5, 1'b1);
    tick();
    set_peak(1'b0, 17'd0, 8'd0, 1'b0);
    n_cmp++; if (bus.cpg_start !== 4'b0001) begin n_err++; $display("FAIL single_start: got %b exp 0001", bus.cpg_start); end
    n_cmp++; if (bus.cpg_r !== 17'd100 || bus.cpg_theta !== 8'd5 || bus.cpg_phase !== 1'b1) begin
      n_err++; $display("FAIL single_payload: got r=%0d th=%0d ph=%b exp 100/5/1", bus.cpg_r, bus.cpg_theta, bus.cpg_phase);
    end
    n_cmp++; if (bus.cpg_busy !== 4'b0001) begin n_err++; $display("FAIL single_busy_t1: got %b exp 0001", bus.cpg_busy); end
    for (int c = 2; c <= 8; c++) begin
      tick();
      n_cmp++; if (bus.cpg_busy !== 4'b0001) begin n_err++; $display("FAIL single_busy_t%0d: got %b exp 0001", c, bus.cpg_busy); end
      n_cmp++; if (bus.cpg_start !== 4'b0000 || bus.cpg_r !== 17'd0) begin
        n_err++; $display("FAIL single_idle_t%0d: got start=%b r=%0d exp 0000/0", c, bus.cpg_start, bus.cpg_r);
      end
    end
    tick();
    n_cmp++; if (bus.cpg_busy !== 4'b0000) begin n_err++; $display("FAIL single_busy_t9: got %b exp 0000", bus.cpg_busy); end
    n_cmp++; if (stat_alloc_cnt !== 16'd1 || stat_drop_cnt !== 16'd0) begin
      n_err++; $display("FAIL single_stats: got alloc=%0d drop=%0d exp 1/0", stat_alloc_cnt, stat_drop_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  exp_start;
    logic [16:0] exp_r;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      set_peak(1'b1, 17'(10 + k), 8'(k), 1'b0);
      tick();
      exp_start = (k < 4) ? 4'(1 << k) : 4'b0000;
      exp_r     = (k < 4) ? 17'(10 + k) : 17'd0;
      n_cmp++; if (bus.cpg_start !== exp_start || bus.cpg_r !== exp_r) begin
        n_err++; $display("FAIL b2b_peak%0d: got start=%b r=%0d exp %b/%0d", k, bus.cpg_start, bus.cpg_r, exp_start, exp_r);
      end
    end
    set_peak(1'b0, 17'd0, 8'd0, 1'b0);
    n_cmp++; if (stat_alloc_cnt !== 16'd4 || stat_drop_cnt !== 16'd1) begin
      n_err++; $display("FAIL b2b_stats: got alloc=%0d drop=%0d exp 4/1", stat_alloc_cnt, stat_drop_cnt);
    end
  endtask

  task automatic test_busy_boundary();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      set_peak(1'b1, 17'(k + 1), 8'd0, 1'b0);
      tick();
    end
    set_peak(1'b0, 17'd0, 8'd0, 1'b0);
    repeat (4) tick();
    n_cmp++; if (bus.cpg_busy !== 4'b1111) begin n_err++; $display("FAIL bnd_busy_t8: got %b exp 1111", bus.cpg_busy); end
    set_peak(1'b1, 17'd77, 8'd7, 1'b1);
    tick();
    n_cmp++; if (bus.cpg_start !== 4'b0000 || stat_drop_cnt !== 16'd1) begin
      n_err++; $display("FAIL bnd_drop_t8: got start=%b drop=%0d exp 0000/1", bus.cpg_start, stat_drop_cnt);
    end
    n_cmp++; if (bus.cpg_busy !== 4'b1110) begin n_err++; $display("FAIL bnd_busy_t9: got %b exp 1110", bus.cpg_busy); end
    set_peak(1'b1, 17'd78, 8'd8, 1'b0);
    tick();
    set_peak(1'b0, 17'd0, 8'd0, 1'b0);
    n_cmp++; if (bus.cpg_start !== 4'b0001 || bus.cpg_r !== 17'd78) begin
      n_err++; $display("FAIL bnd_grant_t9: got start=%b r=%0d exp 0001/78", bus.cpg_start, bus.cpg_r);
    end
  endtask

  task automatic test_mask();
    apply_reset();
    ctrl_cpg_mask = 4'b0100;
    set_peak(1'b1, 17'd150, 8'd3, 1'b1);
    tick();
    set_peak(1'b0, 17'd0, 8'd0, 1'b0);
    n_cmp++; if (bus.cpg_start !== 4'b0100) begin n_err++; $display("FAIL mask_start1: got %b exp 0100", bus.cpg_start); end
    for (int c = 1; c <= 8; c++) begin
      n_cmp++; if (bus.cpg_busy !== 4'b0100) begin n_err++; $display("FAIL mask_busy_t%0d: got %b exp 0100", c, bus.cpg_busy); end
      if (c == 3) ctrl_cpg_mask = 4'b0000;
      tick();
    end
    n_cmp++; if (bus.cpg_busy !== 4'b0000) begin n_err++; $display("FAIL mask_busy_t9: got %b exp 0000", bus.cpg_busy); end
    ctrl_cpg_mask = 4'b0100;
    repeat (11) tick();
    set_peak(1'b1, 17'd200, 8'd9, 1'b0);
    tick();
    set_peak(1'b0, 17'd0, 8'd0, 1'b0);
    n_cmp++; if (bus.cpg_start !== 4'b0100 || bus.cpg_r !== 17'd200) begin
      n_err++; $display("FAIL mask_start2: got start=%b r=%0d exp 0100/200", bus.cpg_start, bus.cpg_r);
    end
    n_cmp++; if (stat_alloc_cnt !== 16'd2) begin n_err++; $display("FAIL mask_alloc: got %0d exp 2", stat_alloc_cnt); end
  endtask

  task automatic test_disable();
    apply_reset();
    set_peak(1'b1, 17'd50, 8'd1, 1'b0);
    tick();
    n_cmp++; if (bus.cpg_start !== 4'b0001) begin n_err++; $display("FAIL dis_pre_start: got %b exp 0001", bus.cpg_start); end
    ctrl_enable = 1'b0;
    stat_clear  = 1'b1;
    set_peak(1'b1, 17'd51, 8'd2, 1'b1);
    for (int c = 2; c <= 4; c++) begin
      tick();
      stat_clear = 1'b0;
      n_cmp++; if (bus.cpg_start !== 4'b0000) begin n_err++; $display("FAIL dis_start_t%0d: got %b exp 0000", c, bus.cpg_start); end
    end
    set_peak(1'b0, 17'd0, 8'd0, 1'b0);
    n_cmp++; if (stat_alloc_cnt !== 16'd0 || stat_drop_cnt !== 16'd0) begin
      n_err++; $display("FAIL dis_stats: got alloc=%0d drop=%0d exp 0/0", stat_alloc_cnt, stat_drop_cnt);
    end
    repeat (4) tick();
    n_cmp++; if (bus.cpg_busy !== 4'b0001) begin n_err++; $display("FAIL dis_busy_t8: got %b exp 0001", bus.cpg_busy); end
    tick();
    n_cmp++; if (bus.cpg_busy !== 4'b0000) begin n_err++; $display("FAIL dis_busy_t9: got %b exp 0000", bus.cpg_busy); end
    ctrl_enable = 1'b1;
  endtask

  task automatic test_async_reset();
    apply_reset();
    set_peak(1'b1, 17'd33, 8'd3, 1'b0);
    tick();
    set_peak(1'b0, 17'd0, 8'd0, 1'b0);
    n_cmp++; if (bus.cpg_start !== 4'b0001) begin n_err++; $display("FAIL arst_pre_start: got %b exp 0001", bus.cpg_start); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.cpg_start !== 4'b0000 || bus.cpg_busy !== 4'b0000) begin
      n_err++; $display("FAIL arst_start_busy: got start=%b busy=%b exp 0000/0000", bus.cpg_start, bus.cpg_busy);
    end
    n_cmp++; if (stat_alloc_cnt !== 16'd0 || bus.cpg_r !== 17'd0) begin
      n_err++; $display("FAIL arst_stats_payload: got alloc=%0d r=%0d exp 0/0", stat_alloc_cnt, bus.cpg_r);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_stat_clear();
    apply_reset();
    ctrl_cpg_mask = 4'b0000;
    set_peak(1'b1, 17'd1, 8'd1, 1'b1);
    tick();
    n_cmp++; if (stat_drop_cnt !== 16'd1) begin n_err++; $display("FAIL clr_drop_t1: got %0d exp 1", stat_drop_cnt); end
    stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
    n_cmp++; if (stat_drop_cnt !== 16'd0) begin n_err++; $display("FAIL clr_priority: got %0d exp 0", stat_drop_cnt); end
    tick();
    set_peak(1'b0, 17'd0, 8'd0, 1'b0);
    n_cmp++; if (stat_drop_cnt !== 16'd1) begin n_err++; $display("FAIL clr_resume: got %0d exp 1", stat_drop_cnt); end
  endtask

  task automatic test_saturation();
    apply_reset();
    ctrl_cpg_mask = 4'b0000;
    force dut.drop_cnt_q = 16'hFFFF;
    #1;
    release dut.drop_cnt_q;
    set_peak(1'b1, 17'd2, 8'd2, 1'b0);
    tick();
    n_cmp++; if (stat_drop_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_drop1: got %h exp ffff", stat_drop_cnt); end
    tick();
    set_peak(1'b0, 17'd0, 8'd0, 1'b0);
    n_cmp++; if (stat_drop_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_drop2: got %h exp ffff", stat_drop_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_boundary();
    test_mask();
    test_disable();
    test_async_reset();
    test_stat_clear();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
